// File: rtl/fabric_pkg.sv
// Shared switch-fabric definitions: half-flit layout, field offsets and the
// ingress packing FSM state type. Also imported by the egress output buffer.
package fabric_pkg;

  localparam int FAB_DATA_WIDTH   = 64;
  localparam int FAB_PACKET_WIDTH = 2 * (FAB_DATA_WIDTH + 7);
  localparam int HF_WIDTH         = FAB_PACKET_WIDTH / 2;

  // Bit offsets inside one half flit.
  localparam int HF_VALID_BIT = HF_WIDTH - 1;
  localparam int HF_SOP_BIT   = HF_WIDTH - 2;
  localparam int HF_EOP_BIT   = HF_WIDTH - 3;
  localparam int HF_EMPTY_MSB = HF_WIDTH - 4;
  localparam int HF_EMPTY_LSB = HF_WIDTH - 6;
  localparam int HF_ERROR_BIT = HF_WIDTH - 7;
  localparam int HF_DATA_MSB  = HF_WIDTH - 8;

  typedef struct packed {
    logic                      valid;
    logic                      sop;
    logic                      eop;
    logic [2:0]                empty;
    logic                      error;
    logic [FAB_DATA_WIDTH-1:0] data;
  } half_flit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } pack_state_e;

endpackage

// File: rtl/ibuffer_if.sv
// Client beat ingress and fabric flit egress bundle for the ibuffer.
// slave = ibuffer side, master = client/fabric side.
interface ibuffer_if
  import fabric_pkg::*;
#(
  parameter int DATA_WIDTH   = FAB_DATA_WIDTH,
  parameter int PACKET_WIDTH = FAB_PACKET_WIDTH,
  parameter int DEPTH        = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    i_valid;
  logic                    i_sop;
  logic                    i_eop;
  logic [DATA_WIDTH-1:0]   i_data;
  logic [2:0]              i_empty;
  logic                    i_error;
  logic                    o_ready;
  logic                    o_valid;
  logic [PACKET_WIDTH-1:0] o_data;
  logic                    i_ready;
  logic [CW-1:0]           o_count;

  modport slave (
    input  i_valid, i_sop, i_eop, i_data, i_empty, i_error, i_ready,
    output o_ready, o_valid, o_data, o_count
  );

  modport master (
    output i_valid, i_sop, i_eop, i_data, i_empty, i_error, i_ready,
    input  o_ready, o_valid, o_data, o_count
  );

endinterface

// File: rtl/ibuffer_flit_fifo.sv
// Synchronous show-ahead FIFO: q is the head entry whenever empty=0, and 0
// otherwise. Writes at full and reads at empty are ignored.
module flit_fifo #(
  parameter  int WIDTH = 142,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrreq,
  input  logic             rdreq,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      usedw
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      usedw_q;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full    = (usedw_q == (AW+1)'(DEPTH));
  assign empty   = (usedw_q == {(AW+1){1'b0}});
  assign usedw   = usedw_q;
  assign wr_en_s = wrreq && !full;
  assign rd_en_s = rdreq && !empty;
  assign q       = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Storage array; contents need no reset because empty masks q.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      usedw_q  <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      end
      if (rd_en_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   usedw_q <= usedw_q + (AW+1)'(1'b1);
        2'b01:   usedw_q <= usedw_q - (AW+1)'(1'b1);
        default: usedw_q <= usedw_q;
      endcase
    end
  end

endmodule

// File: rtl/ibuffer.sv
// Ingress packer: packs pairs of Avalon-ST beats into two-half fabric flits
// and queues them in a show-ahead flit FIFO. Define IBUFFER_ASSERT_EN for
// simulation protocol checks.
`ifdef IBUFFER_ASSERT_EN
module ibuffer_chk
  import fabric_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic        clk,
  input logic        reset,
  input logic        i_valid,
  input logic        i_sop,
  input logic        i_eop,
  input logic [2:0]  i_empty,
  input logic        i_error,
  input logic        o_ready,
  input pack_state_e state,
  input logic [CW-1:0] o_count
);
  // Protocol checks sampled on every clock outside reset.
  always @(posedge clk) begin
    if (!reset) begin
      if (i_valid && $isunknown({i_sop, i_eop, i_empty, i_error})) begin
        $error("%0t ibuffer: unknown control bits on valid beat", $time);
        $finish;
      end else if (i_valid && o_ready && state == ST_IDLE && !i_sop) begin
        $error("%0t ibuffer: beat without sop while idle", $time);
        $finish;
      end else if (i_valid && o_ready && state != ST_IDLE && i_sop) begin
        $error("%0t ibuffer: sop inside an open packet", $time);
        $finish;
      end
      if (int'(o_count) > DEPTH) begin
        $error("%0t ibuffer: o_count exceeds DEPTH", $time);
        $finish;
      end
    end
  end
endmodule
`endif

module ibuffer
  import fabric_pkg::*;
#(
  parameter int PACKET_WIDTH = FAB_PACKET_WIDTH,
  parameter int DATA_WIDTH   = FAB_DATA_WIDTH,
  parameter int DEPTH        = 256
) (
  input logic       clk,
  input logic       reset,
  ibuffer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam half_flit_t HALF_ZERO = half_flit_t'({HF_WIDTH{1'b0}});

  if (PACKET_WIDTH != 2 * (DATA_WIDTH + 7) || DATA_WIDTH != FAB_DATA_WIDTH) begin : g_bad_width
    $error("ibuffer: PACKET_WIDTH must equal 2*(DATA_WIDTH+7)");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ibuffer: DEPTH must be a power of two");
  end

  pack_state_e             state_q, state_d;
  half_flit_t              holder_q, holder_d;
  half_flit_t              beat_s;
  logic                    accept_s;
  logic                    wr_s;
  logic [PACKET_WIDTH-1:0] flit_s;
  logic [PACKET_WIDTH-1:0] fifo_q_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [CW-1:0]           usedw_s;

  assign bus.o_ready = !reset && !fifo_full_s;
  assign bus.o_valid = !fifo_empty_s;
  assign bus.o_data  = fifo_q_s;
  assign bus.o_count = usedw_s;
  assign accept_s    = bus.i_valid && bus.o_ready;

  // Incoming beat as a half flit; sop only survives when it opens a packet.
  always_comb begin
    beat_s.valid = 1'b1;
    beat_s.sop   = (state_q == ST_IDLE) ? bus.i_sop : 1'b0;
    beat_s.eop   = bus.i_eop;
    beat_s.empty = bus.i_empty;
    beat_s.error = bus.i_error;
    beat_s.data  = bus.i_data;
  end

  // Packing FSM next state, holder update and FIFO write.
  always_comb begin
    state_d  = state_q;
    holder_d = holder_q;
    wr_s     = 1'b0;
    flit_s   = {PACKET_WIDTH{1'b0}};
    if (accept_s) begin
      case (state_q)
        ST_IDLE, ST_HI: begin
          if (state_q == ST_IDLE && !bus.i_sop) begin
            state_d = ST_IDLE;
          end else if (bus.i_eop) begin
            wr_s    = 1'b1;
            flit_s  = {beat_s, HALF_ZERO};
            state_d = ST_IDLE;
          end else begin
            holder_d = beat_s;
            state_d  = ST_LO;
          end
        end
        ST_LO: begin
          wr_s     = 1'b1;
          flit_s   = {holder_q, beat_s};
          holder_d = HALF_ZERO;
          state_d  = bus.i_eop ? ST_IDLE : ST_HI;
        end
        default: begin
          holder_d = HALF_ZERO;
          state_d  = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM and holder registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      holder_q <= HALF_ZERO;
    end else begin
      state_q  <= state_d;
      holder_q <= holder_d;
    end
  end

  flit_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (DEPTH)
  ) u_flit_fifo (
    .clk   (clk),
    .reset (reset),
    .wrreq (wr_s),
    .rdreq (bus.i_ready),
    .data  (flit_s),
    .q     (fifo_q_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .usedw (usedw_s)
  );

`ifdef IBUFFER_ASSERT_EN
  ibuffer_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.i_valid),
    .i_sop   (bus.i_sop),
    .i_eop   (bus.i_eop),
    .i_empty (bus.i_empty),
    .i_error (bus.i_error),
    .o_ready (bus.o_ready),
    .state   (state_q),
    .o_count (usedw_s)
  );
`endif

endmodule

// File: tb/tb_ibuffer.sv
// Self-checking bench for ibuffer: a packet-level packing model feeds a flit
// scoreboard that is compared against every popped flit.
module tb_ibuffer;
  import fabric_pkg::*;

  localparam int DW    = 64;
  localparam int PW    = 2 * (DW + 7);
  localparam int HW    = PW / 2;
  localparam int DEPTH = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic rst_d1 = 1'b1;

  ibuffer_if #(.DATA_WIDTH(DW), .PACKET_WIDTH(PW), .DEPTH(DEPTH)) bus ();

  ibuffer #(.PACKET_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [PW-1:0] sb_q[$];
  logic [HW-1:0] hold_half;
  logic          have_hold = 1'b0;
  logic [PW-1:0] last_flit = '0;
  logic [PW-1:0] exp_v;
  int            rdy_mode  = 0;
  logic          rdy_force = 1'b0;

  task automatic check_val(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_half(input logic sop, input logic eop, input logic [2:0] emp,
                                            input logic err, input logic [DW-1:0] d);
    return {1'b1, sop, eop, emp, err, d};
  endfunction

  // Packet-level model: even beat index -> upper half, odd -> lower half.
  task automatic model_beat(input logic [HW-1:0] half, input logic eop);
    if (!have_hold) begin
      if (eop) sb_q.push_back({half, {HW{1'b0}}});
      else begin
        hold_half = half;
        have_hold = 1'b1;
      end
    end else begin
      sb_q.push_back({hold_half, half});
      have_hold = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic sop, input logic eop, input logic [2:0] emp, input logic err,
                           input logic [DW-1:0] d, input logic first, input logic drop);
    int wait_n = 0;
    bus.i_valid = 1'b1;
    bus.i_sop   = sop;
    bus.i_eop   = eop;
    bus.i_empty = emp;
    bus.i_error = err;
    bus.i_data  = d;
    @(negedge clk);
    while (!bus.o_ready && wait_n < 2000) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk);
    if (wait_n >= 2000) check_val("accept_timeout", PW'(1'b0), PW'(1'b1));
    else if (!drop) model_beat(mk_half(first, eop, emp, err, d), eop);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n);
    logic last;
    for (int k = 0; k < n; k++) begin
      last = (k == n - 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat((k == 0) || ($urandom_range(0, 15) == 0), last,
                last ? 3'($urandom_range(0, 7)) : 3'd0,
                ($urandom_range(0, 7) == 0), {$urandom, $urandom}, k == 0, 1'b0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) check_val("drain_timeout", PW'(sb_q.size()), PW'(1'b0));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rst_d1 <= reset;

  always begin
    @(posedge clk);
    #1;
    bus.i_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Output monitor: reset state, occupancy/handshake, and popped flits.
  always @(negedge clk) begin
    if (rst_d1) begin
      check_val("rst_valid", PW'(bus.o_valid), PW'(1'b0));
      check_val("rst_count", PW'(bus.o_count), PW'(1'b0));
      check_val("rst_data", bus.o_data, PW'(1'b0));
      check_val("rst_ready", PW'(bus.o_ready), PW'(!reset));
    end else if (!reset) begin
      check_val("count", PW'(bus.o_count), PW'(sb_q.size()));
      check_val("valid", PW'(bus.o_valid), PW'(sb_q.size() != 0));
      check_val("ready", PW'(bus.o_ready), PW'(sb_q.size() < DEPTH));
      if (bus.o_valid && bus.i_ready && sb_q.size() != 0) begin
        last_flit = bus.o_data;
        check_val("flit", bus.o_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_sop   = 1'b0;
    bus.i_eop   = 1'b0;
    bus.i_empty = 3'd0;
    bus.i_error = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b0;
    rdy_force = 1'b1;
    @(posedge clk);
    #1;

    // 4-beat packet, eop beat empty=3
    send_beat(1'b1, 1'b0, 3'd0, 1'b0, 64'h1, 1'b1, 1'b0);
    send_beat(1'b0, 1'b0, 3'd0, 1'b0, 64'h2, 1'b0, 1'b0);
    send_beat(1'b0, 1'b0, 3'd0, 1'b0, 64'h3, 1'b0, 1'b0);
    send_beat(1'b0, 1'b1, 3'd3, 1'b0, 64'h4, 1'b0, 1'b0);
    drain();
    check_val("t1_lower_eop_empty", PW'(last_flit[HW-3 -: 4]), PW'(4'b1011));

    // 3-beat packet (stray sop on beat 2) then a 1-beat packet
    send_beat(1'b1, 1'b0, 3'd0, 1'b0, 64'h11, 1'b1, 1'b0);
    send_beat(1'b1, 1'b0, 3'd0, 1'b0, 64'h12, 1'b0, 1'b0);
    send_beat(1'b0, 1'b1, 3'd5, 1'b1, 64'h13, 1'b0, 1'b0);
    send_beat(1'b1, 1'b1, 3'd0, 1'b0, 64'hAA, 1'b1, 1'b0);
    drain();
    exp_v = {1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 64'hAA, {HW{1'b0}}};
    check_val("t2_single_beat", last_flit, exp_v);

    // fill the FIFO with i_ready low, then drain
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < DEPTH; p++) send_pkt(2);
    @(negedge clk);
    check_val("full_count", PW'(bus.o_count), PW'(DEPTH));
    check_val("full_ready", PW'(bus.o_ready), PW'(1'b0));
    @(posedge clk);
    #1;
    rdy_force = 1'b1;
    send_pkt(2);
    drain();

    // beat without sop while idle is dropped
    send_beat(1'b0, 1'b0, 3'd0, 1'b0, 64'hDEAD, 1'b0, 1'b1);
    send_beat(1'b1, 1'b0, 3'd0, 1'b0, 64'h21, 1'b1, 1'b0);
    send_beat(1'b0, 1'b1, 3'd1, 1'b0, 64'h22, 1'b0, 1'b0);
    drain();

    // reset one cycle after the upper half is accepted
    send_beat(1'b1, 1'b0, 3'd0, 1'b0, 64'h55, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    have_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send_beat(1'b1, 1'b0, 3'd0, 1'b0, 64'h66, 1'b1, 1'b0);
    send_beat(1'b0, 1'b1, 3'd0, 1'b0, 64'h67, 1'b0, 1'b0);
    drain();
    exp_v = {1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'h66, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 64'h67};
    check_val("t5_fresh_flit", last_flit, exp_v);

    // random valid/ready stress
    rdy_mode = 1;
    for (int p = 0; p < 1000; p++) send_pkt($urandom_range(1, 20));
    rdy_mode  = 0;
    rdy_force = 1'b1;
    @(posedge clk);
    #1;
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
